// File: rtl/coef_pkg.sv
// Shared types and constants for the biquad coefficient update controller.
package coef_pkg;

  localparam int COEF_W = 24;

  // Q8.16 constants.
  localparam logic signed [COEF_W-1:0] Q_ONE   = 24'sd65536;
  localparam logic        [COEF_W-1:0] PI_Q816 = 24'd205887;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    COMMIT_WAIT
  } ctrl_state_t;

  typedef struct packed {
    logic signed [COEF_W-1:0] b0;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
    logic signed [COEF_W-1:0] a0;
    logic signed [COEF_W-1:0] a1;
    logic signed [COEF_W-1:0] a2;
  } coef_set_t;

  // Pass-through filter: b0 = a0 = 1.0, everything else zero.
  localparam coef_set_t COEF_IDENTITY = '{
    b0: Q_ONE, b1: '0, b2: '0,
    a0: Q_ONE, a1: '0, a2: '0
  };

  // Unsigned clamp of a requested cutoff into [lo, hi].
  function automatic logic [COEF_W-1:0] clamp_freq(input logic [COEF_W-1:0] f,
                                                   input logic [COEF_W-1:0] lo,
                                                   input logic [COEF_W-1:0] hi);
    if (f < lo) return lo;
    if (f > hi) return hi;
    return f;
  endfunction

endpackage

// File: rtl/coef_update_ctrl_if.sv
// Request, coefficient-unit and filter-side signals of the update controller.
interface coef_update_ctrl_if #(
  parameter int W = 24
);
  logic         req_valid;
  logic [W-1:0] req_freq;
  logic         sample_tick;
  logic         coef_start;
  logic [W-1:0] coef_freq;
  logic         coef_ready;
  logic [W-1:0] coef_b0_in, coef_b1_in, coef_b2_in;
  logic [W-1:0] coef_a0_in, coef_a1_in, coef_a2_in;
  logic [W-1:0] b0, b1, b2, a0, a1, a2;
  logic         coef_update;
  logic         busy;
  logic         timeout_err;
  logic         err_clr;

  // Controller side.
  modport slave (
    input  req_valid, req_freq, sample_tick, coef_ready, err_clr,
    input  coef_b0_in, coef_b1_in, coef_b2_in, coef_a0_in, coef_a1_in, coef_a2_in,
    output coef_start, coef_freq, coef_update, busy, timeout_err,
    output b0, b1, b2, a0, a1, a2
  );

  // Environment side (requester, coefficient unit, filter).
  modport master (
    output req_valid, req_freq, sample_tick, coef_ready, err_clr,
    output coef_b0_in, coef_b1_in, coef_b2_in, coef_a0_in, coef_a1_in, coef_a2_in,
    input  coef_start, coef_freq, coef_update, busy, timeout_err,
    input  b0, b1, b2, a0, a1, a2
  );
endinterface

// File: rtl/coef_bank.sv
// Shadow and active coefficient registers; the active set only changes as a whole.
module coef_bank
  import coef_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      capture_en,
  input  logic      commit_en,
  input  coef_set_t coef_in,
  output coef_set_t active_o
);

  coef_set_t shadow_q, shadow_d;
  coef_set_t active_q, active_d;

  // Capture into shadow, commit shadow to active.
  always_comb begin
    shadow_d = capture_en ? coef_in  : shadow_q;
    active_d = commit_en  ? shadow_q : active_q;
  end

  // Register both sets.
  // NOTE: non-blocking assignments so every flop samples pre-edge values; the
  // shadow is reset too, so a commit can never expose uninitialised contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= COEF_IDENTITY;
      active_q <= COEF_IDENTITY;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/coef_update_ctrl.sv
// Sequences coefficient recomputation and commits new sets on sample boundaries.
module coef_update_ctrl
  import coef_pkg::*;
#(
  parameter int                      SAMPLE_WIDTH   = COEF_W,
  parameter logic [SAMPLE_WIDTH-1:0] MIN_FREQ       = 24'd256,
  parameter logic [SAMPLE_WIDTH-1:0] MAX_FREQ       = PI_Q816,
  parameter int                      TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            reset_n,
  coef_update_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  ctrl_state_t             state_q, state_d;
  logic                    pending_q, pending_d;
  logic [SAMPLE_WIDTH-1:0] pend_freq_q, pend_freq_d;
  logic [SAMPLE_WIDTH-1:0] active_freq_q, active_freq_d;
  logic [SAMPLE_WIDTH-1:0] coef_freq_q, coef_freq_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    coef_start_q, coef_start_d;
  logic                    coef_update_q, coef_update_d;
  logic                    busy_q, busy_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    capture_en, commit_en;
  coef_set_t               coef_in, active;

  // Next-state, request coalescing and output decode.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    pend_freq_d   = pend_freq_q;
    active_freq_d = active_freq_q;
    coef_freq_d   = coef_freq_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    coef_update_d = 1'b0;
    capture_en    = 1'b0;
    commit_en     = 1'b0;

    if (bus.err_clr) timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          if (pend_freq_q != active_freq_q) begin
            coef_freq_d = pend_freq_q;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // The first two cycles may still show ready from the previous job.
        if (tmo_cnt_q >= CNT_W'(2) && bus.coef_ready) begin
          capture_en = 1'b1;
          state_d    = COMMIT_WAIT;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      COMMIT_WAIT: begin
        if (bus.sample_tick) begin
          commit_en     = 1'b1;
          active_freq_d = coef_freq_q;
          coef_update_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh request overrides any clear made above; latest value wins.
    if (bus.req_valid) begin
      pending_d   = 1'b1;
      pend_freq_d = clamp_freq(bus.req_freq, MIN_FREQ, MAX_FREQ);
    end

    coef_start_d = (state_d == ISSUE);
    busy_d       = (state_d != IDLE) || pending_d;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      pend_freq_q   <= '0;
      active_freq_q <= '0;
      coef_freq_q   <= '0;
      tmo_cnt_q     <= '0;
      coef_start_q  <= 1'b0;
      coef_update_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      pend_freq_q   <= pend_freq_d;
      active_freq_q <= active_freq_d;
      coef_freq_q   <= coef_freq_d;
      tmo_cnt_q     <= tmo_cnt_d;
      coef_start_q  <= coef_start_d;
      coef_update_q <= coef_update_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign coef_in = '{
    b0: bus.coef_b0_in, b1: bus.coef_b1_in, b2: bus.coef_b2_in,
    a0: bus.coef_a0_in, a1: bus.coef_a1_in, a2: bus.coef_a2_in
  };

  coef_bank u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .commit_en  (commit_en),
    .coef_in    (coef_in),
    .active_o   (active)
  );

  assign bus.coef_start  = coef_start_q;
  assign bus.coef_freq   = coef_freq_q;
  assign bus.coef_update = coef_update_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.b0          = active.b0;
  assign bus.b1          = active.b1;
  assign bus.b2          = active.b2;
  assign bus.a0          = active.a0;
  assign bus.a1          = active.a1;
  assign bus.a2          = active.a2;

endmodule

// File: tb/tb_coef_update_ctrl.sv
// Directed bench for coef_update_ctrl with an inline coefficient-unit model.
module tb_coef_update_ctrl;

  localparam int W   = 24;
  localparam int TMO = 4096;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  coef_update_ctrl_if #(.W(W)) bus ();

  coef_update_ctrl #(
    .SAMPLE_WIDTH   (W),
    .MIN_FREQ       (24'd256),
    .MAX_FREQ       (24'd205887),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int start_cnt  = 0;
  int update_cnt = 0;
  int base_s, base_u;

  // Count start and update pulses seen by the environment.
  always @(posedge clk) begin
    if (bus.coef_start === 1'b1)  start_cnt  <= start_cnt + 1;
    if (bus.coef_update === 1'b1) update_cnt <= update_cnt + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req(input int f);
    bus.req_valid = 1'b1;
    bus.req_freq  = W'(f);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.sample_tick = 1'b1;
    tick();
    bus.sample_tick = 1'b0;
  endtask

  // Returns at the negedge where coef_start is high, or fails after 100 cycles.
  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (bus.coef_start === 1'b1) seen = 1'b1;
    end
    check({tag, "_start"}, W'(seen), W'(1));
  endtask

  task automatic drive_set(input int b0, b1, b2, a0, a1, a2);
    bus.coef_b0_in = W'(b0); bus.coef_b1_in = W'(b1); bus.coef_b2_in = W'(b2);
    bus.coef_a0_in = W'(a0); bus.coef_a1_in = W'(a1); bus.coef_a2_in = W'(a2);
  endtask

  // Unit drops stale ready, computes for 'delay' cycles, then presents results.
  task automatic finish_serve(input int delay, input int b0, b1, b2, a0, a1, a2);
    bus.coef_ready = 1'b0;
    tick(delay);
    drive_set(b0, b1, b2, a0, a1, a2);
    bus.coef_ready = 1'b1;
  endtask

  task automatic serve(input int delay, input int b0, b1, b2, a0, a1, a2);
    tick(3);
    finish_serve(delay, b0, b1, b2, a0, a1, a2);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_freq    = '0;
    bus.sample_tick = 1'b0;
    bus.err_clr     = 1'b0;
    // Idle unit shows ready with stale values that must never be captured.
    bus.coef_ready  = 1'b1;
    drive_set(777, 777, 777, 777, 777, 777);
    tick(3);
    reset_n = 1'b1;

    // Reset state, and nothing happens without requests.
    check("rst_b0", bus.b0, W'(65536));
    check("rst_a0", bus.a0, W'(65536));
    check("rst_b1", bus.b1, W'(0));
    check("rst_a2", bus.a2, W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_freq", bus.coef_freq, W'(0));
    check("rst_err", W'(bus.timeout_err), W'(0));
    pulse_tick();
    tick(5);
    check("idle_nostart", W'(start_cnt), W'(0));
    check("idle_b0", bus.b0, W'(65536));

    // Basic request: outputs change only on the sample tick.
    req(296);
    wait_start("basic");
    check("basic_freq", bus.coef_freq, W'(296));
    serve(45, 100, 0, 0, 65536, -200, 0);
    tick(5);
    check("basic_hold_b0", bus.b0, W'(65536));
    check("basic_hold_upd", W'(bus.coef_update), W'(0));
    check("basic_hold_busy", W'(bus.busy), W'(1));
    pulse_tick();
    check("basic_b0", bus.b0, W'(100));
    check("basic_a1", bus.a1, W'(-200));
    check("basic_a0", bus.a0, W'(65536));
    check("basic_upd", W'(bus.coef_update), W'(1));
    tick();
    check("basic_upd_end", W'(bus.coef_update), W'(0));
    check("basic_busy_end", W'(bus.busy), W'(0));
    check("basic_starts", W'(start_cnt), W'(1));

    // Clamp at both ends.
    req(10);
    wait_start("clamp_lo");
    check("clamp_lo_freq", bus.coef_freq, W'(256));
    serve(10, 1, 2, 3, 65536, 4, 5);
    tick(3);
    pulse_tick();
    check("clamp_lo_b2", bus.b2, W'(3));
    req(300000);
    wait_start("clamp_hi");
    check("clamp_hi_freq", bus.coef_freq, W'(205887));
    serve(10, 5, 6, 7, 65536, 8, 9);
    tick(3);
    pulse_tick();
    check("clamp_hi_a2", bus.a2, W'(9));

    // Coalescing: two requests during WAIT_DONE collapse into the last one.
    tick(2);
    base_s = start_cnt;
    req(3272);
    wait_start("coal1");
    check("coal1_freq", bus.coef_freq, W'(3272));
    tick();
    req(6544);
    req(13089);
    finish_serve(10, 10, 11, 12, 65536, 13, 14);
    tick(3);
    pulse_tick();
    check("coal1_b0", bus.b0, W'(10));
    check("coal1_a1", bus.a1, W'(13));
    wait_start("coal2");
    check("coal2_freq", bus.coef_freq, W'(13089));
    serve(10, 20, 21, 22, 65536, 23, 24);
    tick(3);
    pulse_tick();
    check("coal2_b0", bus.b0, W'(20));
    check("coal2_a2", bus.a2, W'(24));
    tick(2);
    check("coal_starts", W'(start_cnt - base_s), W'(2));
    check("coal_busy", W'(bus.busy), W'(0));

    // Duplicate of the active frequency: no start, no update.
    base_s = start_cnt;
    base_u = update_cnt;
    req(13089);
    check("dup_busy_on", W'(bus.busy), W'(1));
    tick();
    check("dup_busy_off", W'(bus.busy), W'(0));
    pulse_tick();
    tick(3);
    check("dup_nostart", W'(start_cnt - base_s), W'(0));
    check("dup_noupd", W'(update_cnt - base_u), W'(0));

    // Timeout: unit never answers.
    bus.coef_ready = 1'b0;
    req(6544);
    wait_start("tmo");
    tick(TMO - 1);
    check("tmo_early", W'(bus.timeout_err), W'(0));
    tick(3);
    check("tmo_set", W'(bus.timeout_err), W'(1));
    check("tmo_b0", bus.b0, W'(20));
    check("tmo_busy", W'(bus.busy), W'(0));
    pulse_tick();
    check("tmo_nocommit", bus.a2, W'(24));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo_clr", W'(bus.timeout_err), W'(0));

    // Reset in the middle of WAIT_DONE.
    req(9000);
    wait_start("rst_mid");
    tick(5);
    reset_n = 1'b0;
    #1;
    check("rst_mid_b0", bus.b0, W'(65536));
    check("rst_mid_b1", bus.b1, W'(0));
    check("rst_mid_busy", W'(bus.busy), W'(0));
    check("rst_mid_freq", bus.coef_freq, W'(0));
    tick();
    reset_n = 1'b1;
    base_s = start_cnt;
    bus.coef_ready = 1'b1;
    pulse_tick();
    tick(10);
    check("rst_mid_idle", W'(start_cnt - base_s), W'(0));
    check("rst_mid_b0_hold", bus.b0, W'(65536));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
